// File: rtl/bus_mem_pkg.sv
// Shared definitions for the bus memory responder.
//   state_e            : responder FSM states (IDLE, BUSY, RESP)
//   DATA_W_DEF/ADDR_W_DEF : default word and address widths
//   MEM_READ/MEM_WRITE : memRW direction encoding
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/bus_mem_responder_mem_array.sv
// mem_array: single-port synchronous storage with a registered read port.
// The word width is set by the instantiating module; it is one bit wider
// than the data when MEM_PARITY_EN is defined there.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (read register only; array is not reset)
//   en_i    : access strobe (commit)
//   we_i    : 1 = write, 0 = read
//   addr_i  : word address
//   wdata_i : write word
//   rdata_o : registered read word, updated only by a read access
module mem_array #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: slow, handshaked memory for the accumulator CPU bus.
// A request is latched in IDLE, held for WAIT_STATES cycles in BUSY, committed
// on the edge entering RESP, and acknowledged with a one-cycle Ack in RESP.
// Optional feature: MEM_PARITY_EN adds an even-parity bit per word and a
// ParErr flag on reads; when undefined ParErr is tied low.
// Ports:
//   CLK    : clock
//   RST_N  : asynchronous active-low reset
//   Req    : request strobe (sampled only in IDLE)
//   memRW  : 0 = read, 1 = write
//   Addr   : word address
//   WData  : write data
//   RData  : registered read data
//   Ack    : one-cycle completion pulse
//   Busy   : high whenever not IDLE
//   ParErr : read parity error, valid with Ack
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req,
  input  logic              memRW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Ack,
  output logic              Busy,
  output logic              ParErr
);

  localparam int unsigned CNT_W = 4;

`ifdef MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              rw_q,    rw_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              commit;

  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= MEM_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          rw_d    = memRW;
          addr_d  = Addr;
          wdata_d = WData;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Ack  = (state_q == RESP);
  assign Busy = (state_q != IDLE);

  // The array is driven from the next-state request values: with zero wait
  // states the commit happens on the same edge that latches the request, so
  // the live inputs must reach the array; otherwise these equal the latched copy.
`ifdef MEM_PARITY_EN
  logic rd_chk_q;

  assign mem_wdata = {^wdata_d, wdata_d};

  // Flag set by a read commit and cleared by a write commit; the stored word's
  // total XOR is stored parity XOR recomputed parity.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_chk_q <= 1'b0;
    end else if (commit) begin
      rd_chk_q <= (rw_d == MEM_READ);
    end
  end

  assign ParErr = rd_chk_q & (^mem_rdata);
`else
  assign mem_wdata = wdata_d;
  assign ParErr    = 1'b0;
`endif

  mem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .en_i    (commit),
    .we_i    (rw_d == MEM_WRITE),
    .addr_i  (addr_d),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign RData = mem_rdata[DATA_W-1:0];

endmodule
